// File: rtl/mem_stage_bus.sv
// MEM stage: drives loads/stores over a req/ack bus and stalls until ack.
// Load data is lane-selected big-endian and sign/zero extended to mem_wb.
module mem_stage_bus #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_whilo,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_store_data,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic        stall_req,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [15:0] TO_LAST = 16'(BUS_TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;

  logic        is_ld, is_st, is_mem;
  logic        is_byte, is_half, is_word;
  logic        misal;
  logic [1:0]  a;
  logic [3:0]  sel_c;
  logic [31:0] wdat_c;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_val;
  logic        to_hit;

  assign a       = ex_mem_addr[1:0];
  assign is_ld   = (ex_mem_op >= 4'd1) && (ex_mem_op <= 4'd5);
  assign is_st   = (ex_mem_op >= 4'd6) && (ex_mem_op <= 4'd8);
  assign is_mem  = is_ld | is_st;
  assign is_byte = (ex_mem_op == 4'd1) || (ex_mem_op == 4'd2)
                || (ex_mem_op == 4'd6);
  assign is_half = (ex_mem_op == 4'd3) || (ex_mem_op == 4'd4)
                || (ex_mem_op == 4'd7);
  assign is_word = (ex_mem_op == 4'd5) || (ex_mem_op == 4'd8);
  assign misal   = (is_half & a[0]) | (is_word & (|a));
  assign to_hit  = (cnt == TO_LAST);

  always_comb begin
    sel_c  = 4'b1000 >> a;
    wdat_c = {4{ex_store_data[7:0]}};
    unique case (1'b1)
      is_word: begin
        sel_c  = 4'b1111;
        wdat_c = ex_store_data;
      end
      is_half: begin
        sel_c  = a[1] ? 4'b0011 : 4'b1100;
        wdat_c = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (a)
      2'b00:   byte_v = bus_rdata[31:24];
      2'b01:   byte_v = bus_rdata[23:16];
      2'b10:   byte_v = bus_rdata[15:8];
      default: byte_v = bus_rdata[7:0];
    endcase
    half_v = a[1] ? bus_rdata[15:0] : bus_rdata[31:16];
    unique case (ex_mem_op)
      4'd1:    ld_val = {{24{byte_v[7]}}, byte_v};
      4'd2:    ld_val = {24'd0, byte_v};
      4'd3:    ld_val = {{16{half_v[15]}}, half_v};
      4'd4:    ld_val = {16'd0, half_v};
      default: ld_val = bus_rdata;
    endcase
  end

  always_comb begin
    mem_wd    = ex_wd;
    mem_wreg  = ex_wreg;
    mem_wdata = ex_wdata;
    mem_hi    = ex_hi;
    mem_lo    = ex_lo;
    mem_whilo = ex_whilo;
    stall_req = 1'b0;
    addr_err  = 1'b0;
    bus_err   = 1'b0;
    if (rst) begin
      mem_wd    = '0;
      mem_wreg  = 1'b0;
      mem_wdata = '0;
      mem_hi    = '0;
      mem_lo    = '0;
      mem_whilo = 1'b0;
    end else if (state == S_WAIT) begin
      mem_wreg = 1'b0;
      if (bus_ack) begin
        if (is_ld) begin
          mem_wreg  = ex_wreg;
          mem_wdata = ld_val;
        end
      end else if (to_hit) begin
        bus_err = 1'b1;
      end else begin
        stall_req = 1'b1;
      end
    end else if (is_mem) begin
      mem_wreg = 1'b0;
      if (misal) addr_err = 1'b1;
      else       stall_req = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_wdata <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (is_mem && !misal) begin
            bus_addr  <= {ex_mem_addr[31:2], 2'b00};
            bus_sel   <= sel_c;
            bus_we    <= is_st;
            bus_wdata <= wdat_c;
            bus_req   <= 1'b1;
            cnt       <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus_ack || to_hit) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_bus.sv
// Directed bench for mem_stage_bus with a short bus timeout.
// Expected values are hand-computed constants.
module tb_mem_stage_bus;

  logic        clk;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic        stall_req;
  logic        addr_err;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  mem_stage_bus #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .ex_wdata(ex_wdata), .ex_hi(ex_hi),
    .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .ex_mem_op(ex_mem_op),
    .ex_mem_addr(ex_mem_addr),
    .ex_store_data(ex_store_data),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .stall_req(stall_req),
    .addr_err(addr_err), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0]  op,
                        input logic [31:0] addr,
                        input logic [31:0] sd,
                        input logic [4:0]  wd,
                        input logic        wreg,
                        input logic [31:0] wdata);
    ex_mem_op     = op;
    ex_mem_addr   = addr;
    ex_store_data = sd;
    ex_wd         = wd;
    ex_wreg       = wreg;
    ex_wdata      = wdata;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus_ack = 1'b0;
    bus_rdata = '0;
    ex_hi = 32'hAA;
    ex_lo = 32'hBB;
    ex_whilo = 1'b1;
    set_op(4'd0, 32'h0, 32'h0, 5'd3, 1'b1, 32'h55);
    tick();
    tick();
    chk("rst_wreg", {31'd0, mem_wreg}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_hi", mem_hi, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_sel", {28'd0, bus_sel}, 32'd0);

    rst = 1'b0;
    set_op(4'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234);
    chk("alu_wd", {27'd0, mem_wd}, 32'd5);
    chk("alu_wreg", {31'd0, mem_wreg}, 32'd1);
    chk("alu_wdata", mem_wdata, 32'h1234);
    chk("alu_hi", mem_hi, 32'hAA);
    chk("alu_lo", mem_lo, 32'hBB);
    chk("alu_stall", {31'd0, stall_req}, 32'd0);
    tick();
    chk("alu_req", {31'd0, bus_req}, 32'd0);

    set_op(4'd1, 32'h101, 32'h0, 5'd7, 1'b1, 32'h0);
    chk("lb_st0", {31'd0, stall_req}, 32'd1);
    chk("lb_wreg0", {31'd0, mem_wreg}, 32'd0);
    tick();
    chk("lb_req", {31'd0, bus_req}, 32'd1);
    chk("lb_sel", {28'd0, bus_sel}, 32'h4);
    chk("lb_we", {31'd0, bus_we}, 32'd0);
    chk("lb_addr", bus_addr, 32'h100);
    chk("lb_st1", {31'd0, stall_req}, 32'd1);
    tick();
    chk("lb_st2", {31'd0, stall_req}, 32'd1);
    tick();
    chk("lb_st3", {31'd0, stall_req}, 32'd1);
    tick();
    bus_ack = 1'b1;
    bus_rdata = 32'h11F0_2233;
    #1;
    chk("lb_st_ack", {31'd0, stall_req}, 32'd0);
    chk("lb_wreg", {31'd0, mem_wreg}, 32'd1);
    chk("lb_data", mem_wdata, 32'hFFFF_FFF0);
    chk("lb_berr", {31'd0, bus_err}, 32'd0);
    tick();
    bus_ack = 1'b0;
    set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    chk("lb_req_off", {31'd0, bus_req}, 32'd0);

    set_op(4'd2, 32'h101, 32'h0, 5'd8, 1'b1, 32'h0);
    tick();
    bus_ack = 1'b1;
    #1;
    chk("lbu_data", mem_wdata, 32'h0000_00F0);
    chk("lbu_wreg", {31'd0, mem_wreg}, 32'd1);
    tick();
    bus_ack = 1'b0;
    set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);

    set_op(4'd7, 32'h202, 32'hAAAA_BEEF, 5'd9, 1'b1, 32'h0);
    chk("sh_st0", {31'd0, stall_req}, 32'd1);
    tick();
    chk("sh_we", {31'd0, bus_we}, 32'd1);
    chk("sh_sel", {28'd0, bus_sel}, 32'h3);
    chk("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", bus_addr, 32'h200);
    bus_ack = 1'b1;
    #1;
    chk("sh_wreg", {31'd0, mem_wreg}, 32'd0);
    chk("sh_stall", {31'd0, stall_req}, 32'd0);
    tick();
    bus_ack = 1'b0;
    set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    chk("sh_we_off", {31'd0, bus_we}, 32'd0);

    set_op(4'd5, 32'h103, 32'h0, 5'd4, 1'b1, 32'h0);
    chk("lw_aerr", {31'd0, addr_err}, 32'd1);
    chk("lw_astall", {31'd0, stall_req}, 32'd0);
    chk("lw_awreg", {31'd0, mem_wreg}, 32'd0);
    chk("lw_awhilo", {31'd0, mem_whilo}, 32'd1);
    tick();
    chk("lw_areq", {31'd0, bus_req}, 32'd0);
    set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    chk("lw_aerr_off", {31'd0, addr_err}, 32'd0);

    set_op(4'd3, 32'h106, 32'h0, 5'd6, 1'b1, 32'h0);
    tick();
    chk("to_sel", {28'd0, bus_sel}, 32'h3);
    chk("to_st0", {31'd0, stall_req}, 32'd1);
    chk("to_e0", {31'd0, bus_err}, 32'd0);
    tick();
    chk("to_st1", {31'd0, stall_req}, 32'd1);
    tick();
    chk("to_st2", {31'd0, stall_req}, 32'd1);
    chk("to_e2", {31'd0, bus_err}, 32'd0);
    tick();
    chk("to_err", {31'd0, bus_err}, 32'd1);
    chk("to_stall", {31'd0, stall_req}, 32'd0);
    chk("to_wreg", {31'd0, mem_wreg}, 32'd0);
    tick();
    set_op(4'd0, 32'h0, 32'h0, 5'd2, 1'b1, 32'h99);
    chk("to_req_off", {31'd0, bus_req}, 32'd0);
    chk("to_err_off", {31'd0, bus_err}, 32'd0);
    bus_ack = 1'b1;
    bus_rdata = 32'h7777_7777;
    #1;
    chk("idle_ack_data", mem_wdata, 32'h99);
    chk("idle_ack_st", {31'd0, stall_req}, 32'd0);
    tick();
    chk("idle_ack_req", {31'd0, bus_req}, 32'd0);
    bus_ack = 1'b0;

    set_op(4'd8, 32'h300, 32'hCAFE_BABE, 5'd0, 1'b0, 32'h0);
    tick();
    chk("sw_req", {31'd0, bus_req}, 32'd1);
    chk("sw_sel", {28'd0, bus_sel}, 32'hF);
    chk("sw_wdata", bus_wdata, 32'hCAFE_BABE);
    rst = 1'b1;
    #1;
    chk("sw_rst_st", {31'd0, stall_req}, 32'd0);
    tick();
    rst = 1'b0;
    chk("sw_rst_req", {31'd0, bus_req}, 32'd0);
    chk("sw_rst_err", {31'd0, bus_err}, 32'd0);
    set_op(4'd5, 32'h404, 32'h0, 5'd11, 1'b1, 32'h0);
    chk("lw2_st0", {31'd0, stall_req}, 32'd1);
    tick();
    chk("lw2_req", {31'd0, bus_req}, 32'd1);
    chk("lw2_addr", bus_addr, 32'h404);
    chk("lw2_we", {31'd0, bus_we}, 32'd0);
    bus_ack = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw2_data", mem_wdata, 32'hDEAD_BEEF);
    chk("lw2_wreg", {31'd0, mem_wreg}, 32'd1);
    tick();
    bus_ack = 1'b0;
    set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    chk("lw2_req_off", {31'd0, bus_req}, 32'd0);

    set_op(4'd3, 32'h102, 32'h0, 5'd12, 1'b1, 32'h0);
    tick();
    bus_ack = 1'b1;
    bus_rdata = 32'h0000_8001;
    #1;
    chk("lh_data", mem_wdata, 32'hFFFF_8001);
    tick();
    bus_ack = 1'b0;
    set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
